// File: rtl/multicycle_processor.sv
// Multi-cycle MIPS-subset core: one register file and one ALU sequenced by a FETCH/DECODE/EXEC/WB FSM.
// Latency: ALU ops 4 cycles, beq and illegal (NOP) 3 cycles, halt 3 cycles to reach HALT.
// Backpressure: none; run and load_en are only accepted in IDLE/HALT and ignored while busy.
module multicycle_processor #(
  parameter int DATA_W  = 32,
  parameter int IMEM_AW = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [IMEM_AW-1:0] load_addr,
  input  logic [31:0]        load_data,
  input  logic               run,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [IMEM_AW-1:0] pc_out,
  output logic               wb_valid,
  output logic [4:0]         wb_addr,
  output logic [DATA_W-1:0]  wb_data
);
  localparam int IMEM_DEPTH = 1 << IMEM_AW;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Instruction memory has no reset so a loaded program survives reset.
  logic [31:0]        r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0]  r_rf   [32];
  logic [31:0]        r_ir;
  logic [IMEM_AW-1:0] r_pc;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_imm;
  logic [DATA_W-1:0]  r_alu;
  logic [4:0]         r_dst;
  logic               r_illegal;

  logic [5:0]         w_opcode;
  logic [5:0]         w_funct;
  logic [4:0]         w_rs;
  logic [4:0]         w_rt;
  logic [4:0]         w_rd;
  logic [15:0]        w_imm;
  logic [DATA_W-1:0]  w_imm_ext;
  logic [IMEM_AW-1:0] w_pc_inc;
  logic [IMEM_AW-1:0] w_br_tgt;
  logic               w_idle;
  logic               w_wb_vld;
  logic               w_alu_vld;
  logic               w_is_beq;
  logic               w_is_halt;
  logic [DATA_W-1:0]  w_alu_res;
  logic [4:0]         w_dst;
  logic               w_unused;

  assign w_opcode = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_funct  = r_ir[5:0];
  assign w_imm    = r_ir[15:0];
  // Shift amount field is not used by any supported instruction.
  assign w_unused = &{1'b0, r_ir[10:6]};

  // Logical immediates are zero-extended, arithmetic/compare ones sign-extended.
  assign w_imm_ext = ((w_opcode == OP_ANDI) || (w_opcode == OP_ORI)) ?
                     DATA_W'(w_imm) : DATA_W'($signed(w_imm));

  // PC arithmetic naturally wraps modulo the instruction memory depth.
  assign w_pc_inc = r_pc + IMEM_AW'(1);
  assign w_br_tgt = w_pc_inc + IMEM_AW'($signed(w_imm));

  assign w_idle   = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_wb_vld = (r_state == S_WB) && (r_dst != 5'd0);

  // Decode the latched instruction and compute the ALU result from latched operands.
  always_comb begin
    w_alu_vld = 1'b0;
    w_is_beq  = 1'b0;
    w_is_halt = 1'b0;
    w_alu_res = '0;
    w_dst     = w_rt;
    case (w_opcode)
      OP_RTYPE: begin
        w_dst     = w_rd;
        w_alu_vld = 1'b1;
        case (w_funct)
          FN_ADD:  w_alu_res = r_a + r_b;
          FN_SUB:  w_alu_res = r_a - r_b;
          FN_AND:  w_alu_res = r_a & r_b;
          FN_OR:   w_alu_res = r_a | r_b;
          FN_NOR:  w_alu_res = ~(r_a | r_b);
          FN_SLT:  w_alu_res = DATA_W'($signed(r_a) < $signed(r_b));
          default: w_alu_vld = 1'b0;
        endcase
      end
      OP_ADDI: begin
        w_alu_vld = 1'b1;
        w_alu_res = r_a + r_imm;
      end
      OP_SLTI: begin
        w_alu_vld = 1'b1;
        w_alu_res = DATA_W'($signed(r_a) < $signed(r_imm));
      end
      OP_ANDI: begin
        w_alu_vld = 1'b1;
        w_alu_res = r_a & r_imm;
      end
      OP_ORI: begin
        w_alu_vld = 1'b1;
        w_alu_res = r_a | r_imm;
      end
      OP_BEQ:  w_is_beq  = 1'b1;
      OP_HALT: w_is_halt = 1'b1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; anything not ALU, beq or halt falls back to FETCH as a NOP.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_HALT: if (run) w_state_nxt = S_FETCH;
      S_FETCH:        w_state_nxt = S_DECODE;
      S_DECODE:       w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_alu_vld)      w_state_nxt = S_WB;
        else if (w_is_halt) w_state_nxt = S_HALT;
        else                w_state_nxt = S_FETCH;
      end
      S_WB:           w_state_nxt = S_FETCH;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: PC, IR, operand latches, ALU result and the sticky illegal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_alu     <= '0;
      r_dst     <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (run) begin
            r_pc      <= '0;
            r_illegal <= 1'b0;
          end
        end
        S_FETCH: r_ir <= r_imem[r_pc];
        S_DECODE: begin
          r_a   <= r_rf[w_rs];
          r_b   <= r_rf[w_rt];
          r_imm <= w_imm_ext;
        end
        S_EXEC: begin
          if (w_alu_vld) begin
            r_alu <= w_alu_res;
            r_dst <= w_dst;
          end else if (w_is_beq) begin
            r_pc <= (r_a == r_b) ? w_br_tgt : w_pc_inc;
          end else if (!w_is_halt) begin
            r_illegal <= 1'b1;
            r_pc      <= w_pc_inc;
          end
        end
        S_WB: r_pc <= w_pc_inc;
        default: ;
      endcase
    end
  end

  // Register file; r0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_wb_vld) begin
      r_rf[r_dst] <= r_alu;
    end
  end

  // Program load port, only honoured while the core is stopped.
  always_ff @(posedge clk) begin
    if (w_idle && load_en) begin
      r_imem[load_addr] <= load_data;
    end
  end

  assign busy     = !w_idle;
  assign halted   = (r_state == S_HALT);
  assign illegal  = r_illegal;
  assign pc_out   = r_pc;
  assign wb_valid = w_wb_vld;
  assign wb_addr  = w_wb_vld ? r_dst : 5'd0;
  assign wb_data  = w_wb_vld ? r_alu : '0;

endmodule

// File: tb/tb_multicycle_processor.sv
// Program-level bench for multicycle_processor (default build plus a 4-word IMEM build).
// Expected writebacks are queued as each program is launched and popped by per-DUT monitors.
// Every wait on the DUT is cycle-bounded; an expired wait shows up as a failed check.
module tb_multicycle_processor;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT
  logic        reset     = 1'b1;
  logic        load_en   = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        run       = 1'b0;
  logic        busy, halted, illegal, wb_valid;
  logic [5:0]  pc_out;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  // IMEM_AW=2 DUT
  logic        reset2     = 1'b1;
  logic        load_en2   = 1'b0;
  logic [1:0]  load_addr2 = '0;
  logic [31:0] load_data2 = '0;
  logic        run2       = 1'b0;
  logic        busy2, halted2, illegal2, wb_valid2;
  logic [1:0]  pc_out2;
  logic [4:0]  wb_addr2;
  logic [31:0] wb_data2;

  multicycle_processor #(.DATA_W(32), .IMEM_AW(6)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .run(run), .busy(busy), .halted(halted),
    .illegal(illegal), .pc_out(pc_out), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data)
  );

  multicycle_processor #(.DATA_W(32), .IMEM_AW(2)) dut2 (
    .clk(clk), .reset(reset2), .load_en(load_en2), .load_addr(load_addr2),
    .load_data(load_data2), .run(run2), .busy(busy2), .halted(halted2),
    .illegal(illegal2), .pc_out(pc_out2), .wb_valid(wb_valid2),
    .wb_addr(wb_addr2), .wb_data(wb_data2)
  );

  wb_t q1[$];
  wb_t q2[$];
  wb_t e1;
  wb_t e2;
  int  n_checks = 0;
  int  n_fail   = 0;

  // Scoreboard monitors: every register write must match the next queued expectation.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got r%0d=%h, expected no write", wb_addr, wb_data);
      end else begin
        e1 = q1.pop_front();
        if (wb_addr !== e1.addr || wb_data !== e1.data) begin
          n_fail++;
          $display("FAIL wb_value: got r%0d=%h, expected r%0d=%h", wb_addr, wb_data, e1.addr, e1.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (wb_valid2 === 1'b1) begin
      n_checks++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL wb2_unexpected: got r%0d=%h, expected no write", wb_addr2, wb_data2);
      end else begin
        e2 = q2.pop_front();
        if (wb_addr2 !== e2.addr || wb_data2 !== e2.data) begin
          n_fail++;
          $display("FAIL wb2_value: got r%0d=%h, expected r%0d=%h", wb_addr2, wb_data2, e2.addr, e2.data);
        end
      end
    end
  end

  task automatic push1(input logic [4:0] a, input logic [31:0] d);
    wb_t e;
    e.addr = a;
    e.data = d;
    q1.push_back(e);
  endtask

  task automatic push2(input logic [4:0] a, input logic [31:0] d);
    wb_t e;
    e.addr = a;
    e.data = d;
    q2.push_back(e);
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_word2(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en2 = 1'b1; load_addr2 = a; load_data2 = d;
    @(negedge clk);
    load_en2 = 1'b0;
  endtask

  // Returns on the falling edge after the rising edge that sampled run.
  task automatic pulse_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic pulse_run2();
    @(negedge clk); run2 = 1'b1;
    @(negedge clk); run2 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic do_reset2();
    @(negedge clk); reset2 = 1'b1;
    @(negedge clk); reset2 = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int c = 0; c < budget && halted !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_q2_empty(input int budget);
    for (int c = 0; c < budget && q2.size() != 0; c++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; reset2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, halted, illegal, wb_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/halted/illegal/wb_valid=%b, expected 0000", {busy, halted, illegal, wb_valid});
    end
    n_checks++;
    if (wb_addr !== 5'd0 || wb_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_wb: got addr=%0d data=%h, expected 0/0", wb_addr, wb_data);
    end
    n_checks++;
    if (pc_out !== 6'd0 || pc_out2 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_pc: got %0d/%0d, expected 0/0", pc_out, pc_out2);
    end
    @(negedge clk);
    reset = 1'b0; reset2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b busy2=%b, expected 0/0", busy, busy2);
    end
  endtask

  task automatic test_basic();
    load_word(6'd0, 32'h20010005);   // addi r1,r0,5
    load_word(6'd1, 32'h00211020);   // add  r2,r1,r1
    load_word(6'd2, 32'hFC000000);   // halt
    push1(5'd1, 32'd5);
    push1(5'd2, 32'd10);
    pulse_run();
    // Cycle 1 is the first FETCH; halt occupies 9..11 and HALT shows from 12.
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin
        n_checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 5'd1 || wb_data !== 32'd5) begin
          n_fail++;
          $display("FAIL basic_wb1_timing: got vld=%b r%0d=%h, expected 1 r1=5", wb_valid, wb_addr, wb_data);
        end
      end
      if (k == 8) begin
        n_checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 5'd2 || wb_data !== 32'd10) begin
          n_fail++;
          $display("FAIL basic_wb2_timing: got vld=%b r%0d=%h, expected 1 r2=a", wb_valid, wb_addr, wb_data);
        end
      end
      if (k == 11) begin
        n_checks++;
        if (busy !== 1'b1 || halted !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_exec_halt: got busy=%b halted=%b, expected 1/0", busy, halted);
        end
      end
      if (k == 12) begin
        n_checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc_out !== 6'd2) begin
          n_fail++;
          $display("FAIL basic_halted: got halted=%b busy=%b pc=%0d, expected 1/0/2", halted, busy, pc_out);
        end
      end
    end
    n_checks++;
    if (q1.size() != 0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got pending=%0d illegal=%b, expected 0/0", q1.size(), illegal);
    end
  endtask

  task automatic test_ext();
    logic [31:0] prog [13];
    prog = '{32'h2003FFFF, 32'h3064FFFF, 32'h0060282A, 32'h00833022,
             32'h00853825, 32'h00804027, 32'h00644824, 32'h286A0000,
             32'h288BFFFF, 32'h340C8001, 32'h0003682A, 32'h00637020,
             32'hFC000000};
    for (int i = 0; i < 13; i++) load_word(6'(i), prog[i]);
    push1(5'd3,  32'hFFFFFFFF);   // addi r3,r0,-1
    push1(5'd4,  32'h0000FFFF);   // andi r4,r3,0xFFFF
    push1(5'd5,  32'h00000001);   // slt  r5,r3,r0
    push1(5'd6,  32'h00010000);   // sub  r6,r4,r3
    push1(5'd7,  32'h0000FFFF);   // or   r7,r4,r5
    push1(5'd8,  32'hFFFF0000);   // nor  r8,r4,r0
    push1(5'd9,  32'h0000FFFF);   // and  r9,r3,r4
    push1(5'd10, 32'h00000001);   // slti r10,r3,0
    push1(5'd11, 32'h00000000);   // slti r11,r4,-1
    push1(5'd12, 32'h00008001);   // ori  r12,r0,0x8001
    push1(5'd13, 32'h00000000);   // slt  r13,r0,r3
    push1(5'd14, 32'hFFFFFFFE);   // add  r14,r3,r3 wraps
    pulse_run();
    wait_halt(200);
    n_checks++;
    if (halted !== 1'b1 || pc_out !== 6'd12) begin
      n_fail++;
      $display("FAIL ext_halt: got halted=%b pc=%0d, expected 1/12", halted, pc_out);
    end
    n_checks++;
    if (q1.size() != 0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_done: got pending=%0d illegal=%b, expected 0/0", q1.size(), illegal);
    end
  endtask

  task automatic test_loop();
    do_reset();
    load_word(6'd0, 32'h20020003);   // addi r2,r0,3
    load_word(6'd1, 32'h20210001);   // addi r1,r1,1
    load_word(6'd2, 32'h10220001);   // beq  r1,r2,+1
    load_word(6'd3, 32'h1000FFFD);   // beq  r0,r0,-3
    load_word(6'd4, 32'hFC000000);   // halt
    push1(5'd2, 32'd3);
    push1(5'd1, 32'd1);
    push1(5'd1, 32'd2);
    push1(5'd1, 32'd3);
    pulse_run();
    wait_halt(300);
    n_checks++;
    if (halted !== 1'b1 || pc_out !== 6'd4) begin
      n_fail++;
      $display("FAIL loop_halt: got halted=%b pc=%0d, expected 1/4", halted, pc_out);
    end
    n_checks++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL loop_count: got %0d writes still pending, expected 0", q1.size());
    end
  endtask

  task automatic test_illegal();
    load_word(6'd0, 32'h20000007);   // addi r0,r0,7 (discarded)
    load_word(6'd1, 32'hF8000000);   // opcode 0x3E
    load_word(6'd2, 32'h00003025);   // or r6,r0,r0 -> r0 must read 0
    load_word(6'd3, 32'hFC000000);   // halt
    for (int pass = 0; pass < 2; pass++) begin
      push1(5'd6, 32'd0);
      pulse_run();
      n_checks++;
      if (illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_cleared_by_run: got %b, expected 0 (pass %0d)", illegal, pass);
      end
      wait_halt(100);
      n_checks++;
      if (halted !== 1'b1 || illegal !== 1'b1 || pc_out !== 6'd3) begin
        n_fail++;
        $display("FAIL illegal_flag: got halted=%b illegal=%b pc=%0d, expected 1/1/3", halted, illegal, pc_out);
      end
      n_checks++;
      if (q1.size() != 0) begin
        n_fail++;
        $display("FAIL illegal_wb: got %0d writes pending, expected 0", q1.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_word(6'd0, 32'h20010005);
    load_word(6'd1, 32'h00211020);
    load_word(6'd2, 32'hFC000000);
    push1(5'd1, 32'd5);
    pulse_run();
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
    end
    // Now in DECODE of add r2,r1,r1.
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, halted, illegal, wb_valid} !== 4'b0000 || pc_out !== 6'd0 ||
        wb_addr !== 5'd0 || wb_data !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got flags=%b pc=%0d addr=%0d data=%h, expected all 0",
               {busy, halted, illegal, wb_valid}, pc_out, wb_addr, wb_data);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (dut.r_rf[2] !== 32'd0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_r2: got r2=%h pending=%0d, expected 0/0", dut.r_rf[2], q1.size());
    end
    push1(5'd1, 32'd5);
    push1(5'd2, 32'd10);
    pulse_run();
    wait_halt(100);
    n_checks++;
    if (halted !== 1'b1 || pc_out !== 6'd2 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_rerun: got halted=%b pc=%0d pending=%0d, expected 1/2/0", halted, pc_out, q1.size());
    end
  endtask

  task automatic test_wrap();
    logic saw3;
    logic wrapped;
    do_reset2();
    for (int i = 0; i < 4; i++) load_word2(2'(i), 32'h20210001);   // addi r1,r1,1 everywhere
    for (int v = 1; v <= 6; v++) push2(5'd1, 32'(v));
    pulse_run2();
    // Attempted overwrite of word 1 with halt while running must be dropped.
    load_word2(2'd1, 32'hFC000000);
    saw3 = 1'b0;
    wrapped = 1'b0;
    for (int c = 0; c < 200 && q2.size() != 0; c++) begin
      @(posedge clk); #1;
      if (pc_out2 === 2'd3) saw3 = 1'b1;
      else if (saw3 && pc_out2 === 2'd0) wrapped = 1'b1;
    end
    n_checks++;
    if (wrapped !== 1'b1 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_pc: got wrapped=%b pending=%0d, expected 1/0", wrapped, q2.size());
    end
    n_checks++;
    if (halted2 !== 1'b0 || busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_busy_load: got halted=%b busy=%b, expected 0/1", halted2, busy2);
    end
    do_reset2();
    q2.delete();
    push2(5'd1, 32'd1);
    push2(5'd1, 32'd2);
    push2(5'd1, 32'd3);
    pulse_run2();
    wait_q2_empty(100);
    n_checks++;
    if (q2.size() != 0 || halted2 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_rerun: got pending=%0d halted=%b, expected 0/0", q2.size(), halted2);
    end
    do_reset2();
    q2.delete();
    load_word2(2'd3, 32'hFC000000);
    push2(5'd1, 32'd1);
    push2(5'd1, 32'd2);
    push2(5'd1, 32'd3);
    pulse_run2();
    for (int c = 0; c < 100 && halted2 !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (halted2 !== 1'b1 || pc_out2 !== 2'd3 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_idle_load: got halted=%b pc=%0d pending=%0d, expected 1/3/0", halted2, pc_out2, q2.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ext();
    test_loop();
    test_illegal();
    test_reset_mid();
    test_wrap();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
